// File: rtl/gdes_rank_unit.sv
// HEFT upward-rank and priority-order unit feeding gdes: one adder/comparator, iterative.
// Optional RANK_SAT_EN: saturating ranks plus a sticky rank_ovf output.
module gdes_rank_unit #(
  parameter  int NUM_TASKS      = 10,
  parameter  int NUM_PROCESSORS = 3,
  parameter  int DATA_WIDTH     = 32,
  parameter  int RANK_WIDTH     = 16,
  localparam int IDX_W          = $clog2(NUM_TASKS)
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          start,
  input  logic [NUM_TASKS*NUM_TASKS*DATA_WIDTH-1:0]     comm_cost_in,
  input  logic [NUM_PROCESSORS*NUM_TASKS*DATA_WIDTH-1:0] exec_time_in,
  output logic                                          busy,
  output logic                                          done,
  output logic                                          error,
  output logic [NUM_TASKS*RANK_WIDTH-1:0]               rank_out,
  output logic [NUM_TASKS*IDX_W-1:0]                    order_out
`ifdef RANK_SAT_EN
  , output logic                                        rank_ovf
`endif
);

  localparam int N  = NUM_TASKS;
  localparam int P  = NUM_PROCESSORS;
  localparam int DW = DATA_WIDTH;
  localparam int RW = RANK_WIDTH;
  localparam int CW = $clog2(N*N);
  localparam int EW = (P*N > 1) ? $clog2(P*N) : 1;
  localparam int PW = (P > 1) ? $clog2(P) : 1;
  localparam logic [IDX_W-1:0] LAST_T = IDX_W'(N-1);
  localparam logic [PW-1:0]    LAST_P = PW'(P-1);
  localparam logic [DW+1:0]    PDIV   = (DW+2)'(P);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_AVG, S_SCAN, S_COMMIT, S_SORT, S_FIN, S_DONE} state_e;

  // Word 0 of every bus sits in the most significant slot.
  logic [DW-1:0] comm_w [N*N];
  logic [DW-1:0] exec_w [P*N];
  for (genvar w = 0; w < N*N; w++) begin : g_comm
    assign comm_w[w] = comm_cost_in[(N*N-1-w)*DW +: DW];
  end
  for (genvar w = 0; w < P*N; w++) begin : g_exec
    assign exec_w[w] = exec_time_in[(P*N-1-w)*DW +: DW];
  end

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  t_q, t_d, j_q, j_d, k_q, k_d, best_q, best_d;
  logic [PW-1:0]     p_q, p_d;
  logic [DW+1:0]     sum_q, sum_d;
  logic [DW:0]       max_q, max_d;
  logic [RW-1:0]     rank_q [N];
  logic [RW-1:0]     rank_d [N];
  logic [IDX_W-1:0]  order_q [N];
  logic [IDX_W-1:0]  order_d [N];
  logic [N-1:0]      used_q, used_d;
  logic              best_vld_q, best_vld_d;
  logic              err_q, err_d;
`ifdef RANK_SAT_EN
  logic              ovf_q, ovf_d;
  logic [DW+2:0]     tot;
  localparam logic [DW+2:0] RLIM = (DW+3)'({RW{1'b1}});
`endif

  logic [CW-1:0]     cidx;
  logic [EW-1:0]     eidx;
  logic [DW-1:0]     cw;
  logic [DW:0]       cand;
  logic              better;
  logic [IDX_W-1:0]  pick;

  always_comb begin
    cidx   = CW'(int'(t_q) * N + int'(j_q));
    eidx   = EW'(int'(p_q) * N + int'(t_q));
    cw     = comm_w[cidx];
    cand   = {1'b0, cw} + (DW+1)'(rank_q[j_q]);
    // Strict compare while scanning upward gives ties to the lower index.
    better = !used_q[j_q] && (!best_vld_q || (rank_q[j_q] > rank_q[best_q]));
    pick   = better ? j_q : best_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_INIT;
      S_INIT:         state_d = S_AVG;
      S_AVG:          if (p_q == LAST_P) state_d = S_SCAN;
      S_SCAN: begin
        if ((cw != '0) && (j_q <= t_q)) state_d = S_DONE;
        else if (j_q == LAST_T)         state_d = S_COMMIT;
      end
      S_COMMIT:       state_d = (t_q == '0) ? S_SORT : S_AVG;
      S_SORT:         if ((j_q == LAST_T) && (k_q == LAST_T)) state_d = S_FIN;
      S_FIN:          state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_IDLE:  ;
      S_DONE:  done = 1'b1;
      default: busy = 1'b1;
    endcase
  end

  always_comb begin
    t_d        = t_q;
    j_d        = j_q;
    k_d        = k_q;
    p_d        = p_q;
    best_d     = best_q;
    best_vld_d = best_vld_q;
    sum_d      = sum_q;
    max_d      = max_q;
    used_d     = used_q;
    err_d      = err_q;
    rank_d     = rank_q;
    order_d    = order_q;
`ifdef RANK_SAT_EN
    ovf_d      = ovf_q;
    tot        = (DW+3)'(sum_q / PDIV) + (DW+3)'(max_q);
`endif
    case (state_q)
      S_IDLE, S_DONE: if (start) begin
        err_d = 1'b0;
        for (int i = 0; i < N; i++) rank_d[i] = '0;
`ifdef RANK_SAT_EN
        ovf_d = 1'b0;
`endif
      end
      S_INIT: begin
        t_d   = LAST_T;
        p_d   = '0;
        sum_d = '0;
      end
      S_AVG: begin
        sum_d = sum_q + (DW+2)'(exec_w[eidx]);
        p_d   = (p_q == LAST_P) ? '0 : p_q + 1'b1;
        j_d   = '0;
        max_d = '0;
      end
      S_SCAN: begin
        j_d = j_q + 1'b1;
        if (cw != '0) begin
          if (j_q <= t_q) begin
            // A backward or self edge means no valid topological order.
            err_d = 1'b1;
            for (int i = 0; i < N; i++) begin
              rank_d[i]  = '0;
              order_d[i] = IDX_W'(i);
            end
          end else if (cand > max_q) begin
            max_d = cand;
          end
        end
      end
      S_COMMIT: begin
`ifdef RANK_SAT_EN
        if (tot > RLIM) begin
          rank_d[t_q] = '1;
          ovf_d       = 1'b1;
        end else begin
          rank_d[t_q] = tot[RW-1:0];
        end
`else
        rank_d[t_q] = RW'(sum_q / PDIV) + RW'(max_q);
`endif
        t_d        = t_q - 1'b1;
        sum_d      = '0;
        p_d        = '0;
        j_d        = '0;
        k_d        = '0;
        used_d     = '0;
        best_vld_d = 1'b0;
      end
      S_SORT: begin
        if (j_q == LAST_T) begin
          order_d[k_q] = pick;
          used_d[pick] = 1'b1;
          best_vld_d   = 1'b0;
          j_d          = '0;
          k_d          = k_q + 1'b1;
        end else begin
          best_d     = pick;
          best_vld_d = best_vld_q | better;
          j_d        = j_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      t_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      p_q        <= '0;
      best_q     <= '0;
      best_vld_q <= 1'b0;
      sum_q      <= '0;
      max_q      <= '0;
      used_q     <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < N; i++) begin
        rank_q[i]  <= '0;
        order_q[i] <= '0;
      end
`ifdef RANK_SAT_EN
      ovf_q      <= 1'b0;
`endif
    end else begin
      t_q        <= t_d;
      j_q        <= j_d;
      k_q        <= k_d;
      p_q        <= p_d;
      best_q     <= best_d;
      best_vld_q <= best_vld_d;
      sum_q      <= sum_d;
      max_q      <= max_d;
      used_q     <= used_d;
      err_q      <= err_d;
      rank_q     <= rank_d;
      order_q    <= order_d;
`ifdef RANK_SAT_EN
      ovf_q      <= ovf_d;
`endif
    end
  end

  for (genvar t = 0; t < N; t++) begin : g_out
    assign rank_out[(N-1-t)*RW +: RW]        = rank_q[t];
    assign order_out[(N-1-t)*IDX_W +: IDX_W] = order_q[t];
  end

  assign error = err_q;
`ifdef RANK_SAT_EN
  assign rank_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_gdes_rank_unit.sv
// Bench for gdes_rank_unit: directed scenarios plus random DAGs against a plain-arithmetic HEFT model.
module tb_gdes_rank_unit;
  localparam int N  = 10;
  localparam int P  = 3;
  localparam int DW = 32;
  localparam int RW = 16;
  localparam int IW = 4;
  localparam int LAT = 242;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  start;
  logic [N*N*DW-1:0]     comm_cost_in;
  logic [P*N*DW-1:0]     exec_time_in;
  logic                  busy, done, error;
  logic [N*RW-1:0]       rank_out;
  logic [N*IW-1:0]       order_out;
`ifdef RANK_SAT_EN
  logic                  rank_ovf;
`endif

  gdes_rank_unit dut (
    .clk(clk), .reset(reset), .start(start),
    .comm_cost_in(comm_cost_in), .exec_time_in(exec_time_in),
    .busy(busy), .done(done), .error(error),
    .rank_out(rank_out), .order_out(order_out)
`ifdef RANK_SAT_EN
    , .rank_ovf(rank_ovf)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit [DW-1:0] comm [N][N];
  bit [DW-1:0] ex   [P][N];
  longint      exp_rank  [N];
  int          exp_order [N];
  bit          exp_err, exp_ovf;
  int          cyc;
  int          ref_rank  [N] = '{112, 80, 82, 81, 70, 65, 44, 37, 45, 15};
  int          ref_order [N] = '{0, 2, 3, 1, 4, 5, 8, 6, 7, 9};
  int          ref_w     [N] = '{14, 19, 15, 13, 12, 13, 12, 11, 17, 15};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic clear_mats();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) comm[i][j] = '0;
      for (int p = 0; p < P; p++) ex[p][i] = '0;
    end
  endtask

  task automatic set_ref();
    clear_mats();
    comm[0][1] = 18; comm[0][2] = 12; comm[0][3] = 9;  comm[0][4] = 11; comm[0][5] = 14;
    comm[1][7] = 19; comm[1][8] = 16; comm[2][6] = 23; comm[3][7] = 27; comm[3][8] = 23;
    comm[4][8] = 13; comm[5][7] = 15; comm[6][9] = 17; comm[7][9] = 11; comm[8][9] = 13;
    for (int t = 0; t < N; t++) begin
      ex[0][t] = ref_w[t] - 1;
      ex[1][t] = ref_w[t];
      ex[2][t] = ref_w[t] + 1;
    end
  endtask

  task automatic pack();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        comm_cost_in[(N*N-1-(i*N+j))*DW +: DW] = comm[i][j];
    for (int p = 0; p < P; p++)
      for (int t = 0; t < N; t++)
        exec_time_in[(P*N-1-(p*N+t))*DW +: DW] = ex[p][t];
  endtask

  // Upward rank from the sink back to the source, then order slot by counting who outranks each task.
  task automatic model();
    longint s, mx, c, tot;
    int pos;
    exp_err = 1'b0;
    exp_ovf = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j <= i; j++)
        if (comm[i][j] != 0) exp_err = 1'b1;
    for (int t = 0; t < N; t++) exp_rank[t] = 0;
    if (exp_err) begin
      for (int k = 0; k < N; k++) exp_order[k] = k;
    end else begin
      for (int t = N-1; t >= 0; t--) begin
        s = 0;
        for (int p = 0; p < P; p++) s += longint'(ex[p][t]);
        mx = 0;
        for (int j = t+1; j < N; j++)
          if (comm[t][j] != 0) begin
            c = longint'(comm[t][j]) + exp_rank[j];
            if (c > mx) mx = c;
          end
        tot = s / P + mx;
`ifdef RANK_SAT_EN
        if (tot > 65535) begin tot = 65535; exp_ovf = 1'b1; end
`else
        tot = tot % 65536;
`endif
        exp_rank[t] = tot;
      end
      for (int t = 0; t < N; t++) begin
        pos = 0;
        for (int u = 0; u < N; u++)
          if (exp_rank[u] > exp_rank[t] || (exp_rank[u] == exp_rank[t] && u < t)) pos++;
        exp_order[pos] = t;
      end
    end
  endtask

  // Pulse start, then count edges after the sampling edge until done; optional re-pulse while busy.
  task automatic run(input int pulse_at, output int c);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("start_accept_done_low", {63'b0, done}, 64'd0);
    chk("start_accept_busy_high", {63'b0, busy}, 64'd1);
    c = 0;
    while (c < 1000) begin
      @(posedge clk);
      c++;
      @(negedge clk);
      start = (c == pulse_at);
      if (done) break;
    end
    start = 1'b0;
  endtask

  task automatic check_model(input string tag);
    model();
    chk({tag, "_done"}, {63'b0, done}, 64'd1);
    chk({tag, "_busy"}, {63'b0, busy}, 64'd0);
    chk({tag, "_error"}, {63'b0, error}, {63'b0, exp_err});
    for (int t = 0; t < N; t++)
      chk($sformatf("%s_rank%0d", tag, t), 64'(rank_out[(N-1-t)*RW +: RW]), 64'(exp_rank[t]));
    for (int k = 0; k < N; k++)
      chk($sformatf("%s_order%0d", tag, k), 64'(order_out[(N-1-k)*IW +: IW]), 64'(exp_order[k]));
`ifdef RANK_SAT_EN
    if (!exp_err) chk({tag, "_ovf"}, {63'b0, rank_ovf}, {63'b0, exp_ovf});
`endif
  endtask

  task automatic check_ref(input string tag);
    chk({tag, "_done"}, {63'b0, done}, 64'd1);
    chk({tag, "_error"}, {63'b0, error}, 64'd0);
    for (int t = 0; t < N; t++)
      chk($sformatf("%s_rank%0d", tag, t), 64'(rank_out[(N-1-t)*RW +: RW]), 64'(ref_rank[t]));
    for (int k = 0; k < N; k++)
      chk($sformatf("%s_order%0d", tag, k), 64'(order_out[(N-1-k)*IW +: IW]), 64'(ref_order[k]));
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    comm_cost_in = '0;
    exec_time_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_error", {63'b0, error}, 64'd0);
    chk("rst_rank", {63'b0, rank_out === '0}, 64'd1);
    chk("rst_order", {63'b0, order_out === '0}, 64'd1);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Reference DAG
    set_ref(); pack();
    run(-1, cyc);
    chk("ref_latency", 64'(cyc), 64'(LAT));
    check_ref("ref");

    // Uniform exec, no edges: all ties
    clear_mats();
    for (int p = 0; p < P; p++) for (int t = 0; t < N; t++) ex[p][t] = 6;
    pack();
    run(-1, cyc);
    chk("tie_latency", 64'(cyc), 64'(LAT));
    check_model("tie");
    chk("tie_rank0_const", 64'(rank_out[(N-1)*RW +: RW]), 64'd6);

    // Backward edge
    set_ref(); comm[3][1] = 5; pack();
    run(-1, cyc);
    chk("err_early", {63'b0, cyc < LAT}, 64'd1);
    check_model("err");
    chk("err_flag_const", {63'b0, error}, 64'd1);

    // Reset mid-run, then a clean rerun
    set_ref(); pack();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (99) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_busy", {63'b0, busy}, 64'd0);
    chk("midrst_done", {63'b0, done}, 64'd0);
    chk("midrst_error", {63'b0, error}, 64'd0);
    chk("midrst_rank", {63'b0, rank_out === '0}, 64'd1);
    chk("midrst_order", {63'b0, order_out === '0}, 64'd1);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    run(-1, cyc);
    chk("rerun_latency", 64'(cyc), 64'(LAT));
    check_ref("rerun");

    // start while busy is ignored; start in DONE begins a new run (checked inside run)
    run(50, cyc);
    chk("repulse_latency", 64'(cyc), 64'(LAT));
    check_ref("repulse");

    // Long chain of maximal words: wraps (or saturates with RANK_SAT_EN)
    clear_mats();
    for (int t = 0; t < N; t++) for (int p = 0; p < P; p++) ex[p][t] = 32'hFFFF;
    for (int t = 0; t < N-1; t++) comm[t][t+1] = 32'hFFFF;
    pack();
    run(-1, cyc);
    chk("wrap_latency", 64'(cyc), 64'(LAT));
    check_model("wrap");

    // Random DAGs, some with a planted backward edge
    for (int it = 0; it < 6; it++) begin
      clear_mats();
      for (int t = 0; t < N; t++) for (int p = 0; p < P; p++) ex[p][t] = $urandom_range(1, 100);
      for (int i = 0; i < N; i++)
        for (int j = i+1; j < N; j++)
          if ($urandom_range(0, 99) < 35) comm[i][j] = $urandom_range(1, 200);
      if (it % 3 == 2) begin
        int bi, bj;
        bi = $urandom_range(0, N-1);
        bj = $urandom_range(0, bi);
        comm[bi][bj] = $urandom_range(1, 50);
      end
      pack();
      run(-1, cyc);
      model();
      if (exp_err) chk($sformatf("rnd%0d_early", it), {63'b0, cyc < LAT}, 64'd1);
      else         chk($sformatf("rnd%0d_latency", it), 64'(cyc), 64'(LAT));
      check_model($sformatf("rnd%0d", it));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
